adc_burst_reader: RTL
=====================

Name: adc_burst_reader

Overview:
- Synthesisable controller for a parallel-bus, multi-group simultaneous-sampling ADC (CONVST_x / BUSY / CS_N / RD_N / DB).
- Issues a conversion pulse, waits for BUSY, then bursts N_CH words out of DB. Presents each word as a tagged sample stream to downstream localisation logic.
- Generalises the fixed 4-group, 5-read, free-running pattern to parametrised channel count, width, group count and timing.
- Adds single-shot and continuous modes and a conversion timeout.

Parameters:
- N_CH, 8, words read per conversion frame (1..16)
- DW, 16, DB / sample width
- N_GRP, 4, number of CONVST group outputs
- T_CONVST, 8, CONVST high time in XCLK cycles (>=1)
- T_RD_LO, 1, RD_N low cycles per word (>=1)
- T_RD_HI, 1, RD_N high cycles between words (>=1)
- T_QUIET, 4, cycles CS_N high after a burst before the next CONVST (>=1)
- BUSY_TO, 64, max cycles from CONVST fall to synced BUSY rise, and from BUSY rise to BUSY fall

Ports:
- XCLK  in  1  system clock
- RST  in  1  synchronous active-high reset
- start  in  1  one-cycle request for a frame; honoured only in IDLE
- cont  in  1  1 = re-trigger automatically after T_QUIET; sampled at each QUIET exit
- grp_mask  in  N_GRP  enables each CONVST group; latched at start
- CONVST  out  N_GRP  conversion start pulses, active high
- BUSY  in  1  ADC busy, asynchronous to XCLK
- CS_N  out  1  chip select, active low
- RD_N  out  1  read strobe, active low
- WR_N  out  1  tied high (write path unused)
- DB  in  DW  ADC data bus
- smp_valid  out  1  one-cycle strobe, sample present
- smp_data  out  DW  sample word
- smp_ch  out  $clog2(N_CH) (min 1)  channel index 0..N_CH-1
- frame_done  out  1  one-cycle pulse after last word of a frame
- timeout_err  out  1  one-cycle pulse on BUSY timeout
- active  out  1  high in any state except IDLE

Behaviour:
- Reset values: CONVST=0, CS_N=1, RD_N=1, WR_N=1, smp_valid=0, smp_data=0, smp_ch=0, frame_done=0, timeout_err=0, active=0. FSM=IDLE, counters=0.
- Reset mid-operation returns every output to its reset value on the same edge; a partial frame is discarded with no frame_done.
- BUSY passes through a 2-flop synchroniser (busy_s). All BUSY decisions use busy_s.
- States: IDLE -> PULSE -> WAIT_RISE -> WAIT_FALL -> RD_LO <-> RD_HI -> QUIET -> (PULSE if cont else IDLE).
- IDLE: start=1 latches grp_mask and enters PULSE. start with grp_mask=0 is ignored (stays IDLE). start in any other state is ignored.
- PULSE: CONVST = latched mask for exactly T_CONVST cycles, then 0 and go to WAIT_RISE.
- WAIT_RISE: busy_s=1 -> WAIT_FALL. BUSY_TO cycles elapse without it -> timeout_err pulse, go to IDLE.
- WAIT_FALL: busy_s=0 -> RD_LO with CS_N=0 and word index 0. BUSY_TO cycles elapse without it -> timeout_err pulse, go to IDLE.
- If BUSY rises and falls within one synchroniser window and is never seen high, the frame times out (documented limitation).
- RD_LO: RD_N=0 for T_RD_LO cycles. DB is captured on the edge ending the last low cycle, which is also when RD_N rises.
- Next cycle after capture: smp_valid=1, smp_data=captured word, smp_ch=word index.
- After RD_HI (T_RD_HI cycles, RD_N=1, CS_N=0): next word, or after word N_CH-1 leave RD_HI with CS_N=1 and enter QUIET.
- frame_done pulses in the same cycle as the smp_valid for word N_CH-1.
- CS_N stays low continuously through all N_CH reads of a frame. It is high in every other state.
- QUIET: CS_N=1 for T_QUIET cycles.
- On QUIET exit, cont=1 re-enters PULSE with the same latched mask; cont=0 goes to IDLE. A start during QUIET is ignored.
- timeout_err and frame_done are never high in the same cycle.
- Channel index wraps only via frame restart; it never exceeds N_CH-1.

Test Plan:
- Single frame: defaults, start=1, grp_mask=4'b1111, model BUSY high 20 cycles, DB=16'hA000+idx.
  - CONVST=4'hF for 8 cycles.
  - 8 smp_valid strobes, data A000..A007, ch 0..7.
  - frame_done with ch 7; CS_N low one contiguous window; active back to 0.
- Timeout: BUSY held low after start -> timeout_err exactly one pulse 64 cycles after CONVST fall (plus sync), no smp_valid, no CS_N low, FSM IDLE.
- Continuous: cont=1 for 3 frames, grp_mask=4'b0101 -> CONVST only bits 0,2. Next CONVST rises exactly T_QUIET cycles after CS_N rises. 24 samples total.
- Params N_CH=5, T_RD_LO=3, T_RD_HI=2 -> RD_N low 3 / high 2 cycles, 5 samples, ch 0..4. DB changed during RD_N low is sampled at the last low cycle.
- RST asserted during the 4th read -> next edge: CS_N=1, RD_N=1, smp_valid=0, no frame_done. A start after reset runs a clean frame starting at ch 0.
- start pulses during WAIT_FALL and QUIET are ignored; start with grp_mask=0 in IDLE is ignored (active stays 0).

Source files
------------

// File: rtl/adc_burst_reader.sv
// Burst reader for a parallel-bus simultaneous-sampling ADC: pulses CONVST, waits out BUSY,
// then reads N_CH words over CS_N/RD_N and emits them as a tagged sample stream.
//
// state     | meaning
// S_IDLE    | waiting for start with a non-zero group mask
// S_PULSE   | CONVST driven with latched mask for T_CONVST cycles
// S_WAIT_RISE | waiting for synced BUSY high, bounded by BUSY_TO
// S_WAIT_FALL | waiting for synced BUSY low, bounded by BUSY_TO
// S_RD_LO   | CS_N and RD_N low; DB captured on the last low cycle
// S_RD_HI   | CS_N low, RD_N high between words
// S_QUIET   | CS_N high for T_QUIET cycles, then re-trigger or idle
module adc_burst_reader #(
  parameter int N_CH     = 8,
  parameter int DW       = 16,
  parameter int N_GRP    = 4,
  parameter int T_CONVST = 8,
  parameter int T_RD_LO  = 1,
  parameter int T_RD_HI  = 1,
  parameter int T_QUIET  = 4,
  parameter int BUSY_TO  = 64,
  localparam int CHW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             XCLK,
  input  logic             RST,
  input  logic             start,
  input  logic             cont,
  input  logic [N_GRP-1:0] grp_mask,
  output logic [N_GRP-1:0] CONVST,
  input  logic             BUSY,
  output logic             CS_N,
  output logic             RD_N,
  output logic             WR_N,
  input  logic [DW-1:0]    DB,
  output logic             smp_valid,
  output logic [DW-1:0]    smp_data,
  output logic [CHW-1:0]   smp_ch,
  output logic             frame_done,
  output logic             timeout_err,
  output logic             active
);

  localparam int TMAX_A = (T_CONVST > BUSY_TO) ? T_CONVST : BUSY_TO;
  localparam int TMAX_B = (T_RD_LO > T_RD_HI) ? T_RD_LO : T_RD_HI;
  localparam int TMAX_C = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
  localparam int TMAX   = (TMAX_C > T_QUIET) ? TMAX_C : T_QUIET;
  localparam int TW     = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PULSE, S_WAIT_RISE, S_WAIT_FALL, S_RD_LO, S_RD_HI, S_QUIET
  } state_t;

  state_t           state, state_nx;
  logic [TW-1:0]    tmr, tmr_nx;
  logic [CHW-1:0]   idx, idx_nx;
  logic [N_GRP-1:0] mask, mask_nx;
  logic             busy_m, busy_s;
  logic             tmr_tc, last_word, capture, timeout_nx;

  assign tmr_tc    = (tmr == '0);
  assign last_word = (idx == CHW'(N_CH - 1));

  always_comb begin
    state_nx   = state;
    tmr_nx     = tmr;
    idx_nx     = idx;
    mask_nx    = mask;
    capture    = 1'b0;
    timeout_nx = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && (grp_mask != '0)) begin
          mask_nx  = grp_mask;
          tmr_nx   = TW'(T_CONVST - 1);
          state_nx = S_PULSE;
        end
      end
      S_PULSE: begin
        if (tmr_tc) begin
          tmr_nx   = TW'(BUSY_TO - 1);
          state_nx = S_WAIT_RISE;
        end else begin
          tmr_nx = tmr - TW'(1);
        end
      end
      S_WAIT_RISE: begin
        if (busy_s) begin
          tmr_nx   = TW'(BUSY_TO - 1);
          state_nx = S_WAIT_FALL;
        end else if (tmr_tc) begin
          timeout_nx = 1'b1;
          state_nx   = S_IDLE;
        end else begin
          tmr_nx = tmr - TW'(1);
        end
      end
      S_WAIT_FALL: begin
        if (!busy_s) begin
          idx_nx   = '0;
          tmr_nx   = TW'(T_RD_LO - 1);
          state_nx = S_RD_LO;
        end else if (tmr_tc) begin
          timeout_nx = 1'b1;
          state_nx   = S_IDLE;
        end else begin
          tmr_nx = tmr - TW'(1);
        end
      end
      S_RD_LO: begin
        if (tmr_tc) begin
          capture  = 1'b1;
          tmr_nx   = TW'(T_RD_HI - 1);
          state_nx = S_RD_HI;
        end else begin
          tmr_nx = tmr - TW'(1);
        end
      end
      S_RD_HI: begin
        if (tmr_tc) begin
          if (last_word) begin
            tmr_nx   = TW'(T_QUIET - 1);
            state_nx = S_QUIET;
          end else begin
            idx_nx   = idx + CHW'(1);
            tmr_nx   = TW'(T_RD_LO - 1);
            state_nx = S_RD_LO;
          end
        end else begin
          tmr_nx = tmr - TW'(1);
        end
      end
      S_QUIET: begin
        if (tmr_tc) begin
          if (cont) begin
            tmr_nx   = TW'(T_CONVST - 1);
            state_nx = S_PULSE;
          end else begin
            state_nx = S_IDLE;
          end
        end else begin
          tmr_nx = tmr - TW'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge XCLK) begin
    if (RST) begin
      state       <= S_IDLE;
      tmr         <= '0;
      idx         <= '0;
      mask        <= '0;
      busy_m      <= 1'b0;
      busy_s      <= 1'b0;
      smp_valid   <= 1'b0;
      smp_data    <= '0;
      smp_ch      <= '0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      tmr         <= tmr_nx;
      idx         <= idx_nx;
      mask        <= mask_nx;
      busy_m      <= BUSY;
      busy_s      <= busy_m;
      smp_valid   <= capture;
      frame_done  <= capture && last_word;
      timeout_err <= timeout_nx;
      if (capture) begin
        smp_data <= DB;
        smp_ch   <= idx;
      end
    end
  end

  // CS_N spans both read phases so it stays low for the whole burst
  assign CONVST = (state == S_PULSE) ? mask : '0;
  assign CS_N   = !((state == S_RD_LO) || (state == S_RD_HI));
  assign RD_N   = (state != S_RD_LO);
  assign WR_N   = 1'b1;
  assign active = (state != S_IDLE);

endmodule
